branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Dynamic branch predictor for the five-stage RISC-V pipeline: supplies the `Predict_branchF` / `Predict_targetF` pair that the fetch stage forwards down the pipe with the instruction, and consumes the resolved branch outcome from the execute stage to train itself. It holds a direct-mapped table of 2-bit saturating counters with tagged branch-target entries. It also flags mispredictions and keeps branch and mispredict statistics. Lookup is combinational in F; training is a synchronous write from E.

## Interface
- `ENTRIES`, 64: table depth; power of two, 4..256.
- `IDX`, $clog2(ENTRIES): index width; tag width is TAGW = 30-IDX.
- `clk  in  1`: the single clock for this block.
- `rst  in  1`: asynchronous, active-low reset.
- `PCF  in  32`: fetch PC; lookup address.
- `Predict_branchF  out  1`: predict taken.
- `Predict_targetF  out  32`: predicted next PC.
- `BranchE  in  1`: a conditional branch is resolving in E this cycle; this is the training strobe.
- `PCE  in  32`: PC of the resolving branch.
- `TakenE  in  1`: actual outcome.
- `TargetE  in  32`: actual taken target, PCE+imm.
- `Predict_branchE  in  1`: prediction that travelled with the branch.
- `MispredictE  out  1`: BranchE & (Predict_branchE != TakenE); combinational.
- `BranchCount  out  32`: number of resolved branches.
- `MispredictCount  out  32`: number of mispredicted branches.

## Operation
- Per-entry state: valid bit, TAGW-bit tag, 32-bit target, and a 2-bit counter with these encodings: SN=00, WN=01, WT=10, ST=11.
- Addressing: index = PC[IDX+1:2]; tag = PC[31:IDX+2]; PC[1:0] is ignored.
- Lookup, fully combinational from PCF:
  - hit = valid[idx] & (tag[idx] == PCF tag).
  - Predict_branchF = hit & ctr[idx][1].
  - Predict_targetF = Predict_branchF ? target[idx] : PCF+4, wrapping modulo 2^32.
- Update, on the rising clk edge with BranchE=1, using the PCE index and tag:
  - Tag hit, TakenE=1: ctr saturating-increments, capped at ST. The target is overwritten with TargetE.
  - Tag hit, TakenE=0: ctr saturating-decrements, floored at SN. The target is unchanged.
  - Miss (invalid entry or tag mismatch): allocate the entry. Set valid=1, tag=PCE tag, target=TargetE, ctr = TakenE ? WT : WN. Any prior occupant is evicted.
- BranchE=0: the tables are untouched.
- Squashed branches: the E-stage flush already zeroes BranchE, so they never train the predictor.
- Statistics:
  - BranchCount increments on every cycle with BranchE=1.
  - MispredictCount increments on every cycle with MispredictE=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Reset (rst=0), asynchronous: all valid bits 0, all counters WN, all tags and targets 0, both statistics counters 0. With the table empty, Predict_branchF=0 and Predict_targetF=PCF+4. MispredictE follows its inputs.

## Timing
- Lookup latency is 0 cycles; outputs settle combinationally from PCF and the current table state.
- An update written at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle read and write to the same index: the lookup returns the pre-update contents. There is no write-through bypass.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock. The first update is accepted at the first rising edge after rst deasserts.
- Statistics counters update on the same edge as the table write.
- Only one update per cycle is possible; there is no stall or handshake.

## Test plan
- **Reset defaults:** rst=0, then release; PCF=0x100 -> Predict_branchF=0, Predict_targetF=0x104, BranchCount=0, MispredictCount=0.
- **Allocate then predict:**
  - BranchE=1, PCE=0x100, TakenE=1, TargetE=0x80, Predict_branchE=0 -> MispredictE=1 in that cycle.
  - Next cycle, PCF=0x100 -> Predict_branchF=1, Predict_targetF=0x80. MispredictCount=1, BranchCount=1.
- **Saturation and hysteresis:**
  - Starting from WT, apply two taken updates -> ST. A third taken update stays at ST.
  - Then one not-taken update -> WT, still predicts taken. A second not-taken update -> WN, predict 0.
  - Four more not-taken updates -> stays at SN.
- **Tag alias, ENTRIES=64:**
  - Train PCE=0x100 taken.
  - Lookup PCF=0x200 (same index, different tag) -> Predict_branchF=0, target 0x204.
  - Update PCE=0x200 not-taken -> entry re-allocated at WN. Lookup 0x100 -> Predict_branchF=0.
- **Same-cycle read and write:** PCF=PCE=0x140 on a miss, BranchE=1, TakenE=1 -> Predict_branchF=0 that cycle, 1 the next.
- **Counter wrap and async reset:**
  - Force BranchCount to 0xFFFFFFFF, apply BranchE=1 -> 0.
  - Assert rst between clock edges -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped BHT of 2-bit saturating counters with tagged targets,
// combinational fetch lookup, execute-stage training and branch/mispredict statistics.
module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int IDX = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        Predict_branchF,
  output logic [31:0] Predict_targetF,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic [31:0] TargetE,
  input  logic        Predict_branchE,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);
  localparam int TAGW = 30 - IDX;
  logic [ENTRIES-1:0] valid;
  logic [TAGW-1:0] tagMem [ENTRIES];
  logic [31:0] targetMem [ENTRIES];
  logic [1:0] ctrMem [ENTRIES];
  logic [IDX-1:0] idxF, idxE;
  logic [TAGW-1:0] tagF, tagE;
  logic hitF, hitE;
  logic [1:0] ctrE, ctrNext;
  logic unusedBits;
  assign unusedBits = ^{PCF[1:0], PCE[1:0]};
  assign idxF = PCF[IDX+1:2];
  assign tagF = PCF[31:IDX+2];
  assign idxE = PCE[IDX+1:2];
  assign tagE = PCE[31:IDX+2];
  assign hitF = valid[idxF] && (tagMem[idxF] == tagF);
  assign hitE = valid[idxE] && (tagMem[idxE] == tagE);
  assign ctrE = ctrMem[idxE];
  assign Predict_branchF = hitF & ctrMem[idxF][1];
  assign Predict_targetF = Predict_branchF ? targetMem[idxF] : PCF + 32'd4;
  assign MispredictE = BranchE & (Predict_branchE != TakenE);
  // a miss allocates weakly in the observed direction; a hit moves one step with saturation
  always_comb
    ctrNext = !hitE ? (TakenE ? 2'b10 : 2'b01)
            : TakenE ? (&ctrE ? ctrE : ctrE + 2'd1)
            : (|ctrE ? ctrE - 2'd1 : ctrE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagMem[i] <= '0;
        targetMem[i] <= '0;
        ctrMem[i] <= 2'b01;
      end
      BranchCount <= '0;
      MispredictCount <= '0;
    end else begin
      if (BranchE) begin
        valid[idxE] <= 1'b1;
        tagMem[idxE] <= tagE;
        ctrMem[idxE] <= ctrNext;
        if (!hitE || TakenE) targetMem[idxE] <= TargetE;
        BranchCount <= BranchCount + 32'd1;
      end
      if (MispredictE) MispredictCount <= MispredictCount + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed scenarios plus randomized traffic checked against a
// table-of-records reference model of the predictor.
module tb_branch_predictor_bht;
  localparam int ENTRIES = 64;
  localparam int IDX = 6;
  logic clk = 0, rst = 0;
  logic [31:0] PCF = 0, PCE = 0, TargetE = 0;
  logic BranchE = 0, TakenE = 0, Predict_branchE = 0;
  logic Predict_branchF, MispredictE;
  logic [31:0] Predict_targetF, BranchCount, MispredictCount;
  int tests = 0, fails = 0;

  branch_predictor_bht #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .Predict_branchF(Predict_branchF),
    .Predict_targetF(Predict_targetF), .BranchE(BranchE), .PCE(PCE), .TakenE(TakenE),
    .TargetE(TargetE), .Predict_branchE(Predict_branchE), .MispredictE(MispredictE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  // reference model: one record per slot, counter kept as a plain integer 0..3
  bit mValid [ENTRIES];
  logic [31:0] mTag [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int mCtr [ENTRIES];
  logic [31:0] mBranch, mMisp;

  function automatic void mReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCtr[i] = 1;
    end
    mBranch = 0; mMisp = 0;
  endfunction

  function automatic int slotOf(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit mPred(logic [31:0] pc);
    int s = slotOf(pc);
    return mValid[s] && mTag[s] == (pc >> (IDX + 2)) && mCtr[s] >= 2;
  endfunction

  function automatic logic [31:0] mTgt(logic [31:0] pc);
    return mPred(pc) ? mTarget[slotOf(pc)] : pc + 32'd4;
  endfunction

  function automatic void mUpdate(logic [31:0] pc, bit taken, logic [31:0] tgt, bit predE);
    int s = slotOf(pc);
    if (mValid[s] && mTag[s] == (pc >> (IDX + 2))) begin
      mCtr[s] = taken ? (mCtr[s] < 3 ? mCtr[s] + 1 : 3) : (mCtr[s] > 0 ? mCtr[s] - 1 : 0);
      if (taken) mTarget[s] = tgt;
    end else begin
      mValid[s] = 1; mTag[s] = pc >> (IDX + 2); mTarget[s] = tgt; mCtr[s] = taken ? 2 : 1;
    end
    mBranch = mBranch + 1;
    if (predE != taken) mMisp = mMisp + 1;
  endfunction

  task automatic drive(input bit b, input logic [31:0] pce, input bit taken,
                       input logic [31:0] tgt, input bit predE, input logic [31:0] pcf);
    BranchE = b; PCE = pce; TakenE = taken; TargetE = tgt; Predict_branchE = predE; PCF = pcf;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (BranchE) mUpdate(PCE, TakenE, TargetE, Predict_branchE);
    @(negedge clk);
    BranchE = 0;
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    drive(1, pc, taken, tgt, mPred(pc), pc);
    tick();
  endtask

  task automatic test_reset();
    rst = 0; mReset();
    #12; rst = 1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h100);
    tests++; if (Predict_branchF !== 1'b0) begin fails++; $display("FAIL reset_pred got %0b want 0", Predict_branchF); end
    tests++; if (Predict_targetF !== 32'h104) begin fails++; $display("FAIL reset_target got %h want 00000104", Predict_targetF); end
    tests++; if (BranchCount !== 0 || MispredictCount !== 0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", BranchCount, MispredictCount); end
  endtask

  task automatic test_allocate();
    drive(1, 32'h100, 1, 32'h80, 0, 32'h100);
    tests++; if (MispredictE !== 1'b1) begin fails++; $display("FAIL alloc_mispredict got %0b want 1", MispredictE); end
    tick();
    drive(0, 0, 0, 0, 0, 32'h100);
    tests++; if (Predict_branchF !== 1'b1 || Predict_targetF !== 32'h80) begin fails++; $display("FAIL alloc_predict got %0b/%h want 1/00000080", Predict_branchF, Predict_targetF); end
    tests++; if (BranchCount !== 1 || MispredictCount !== 1) begin fails++; $display("FAIL alloc_counts got %0d/%0d want 1/1", BranchCount, MispredictCount); end
  endtask

  task automatic test_saturation();
    bit expP [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    bit tk [12]   = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 12; i++) begin
      train(32'h300, tk[i], 32'h1000 + 32'(i * 4));
      drive(0, 0, 0, 0, 0, 32'h300);
      tests++;
      if (Predict_branchF !== expP[i] || Predict_branchF !== mPred(32'h300)) begin
        fails++; $display("FAIL sat_step%0d got %0b want %0b", i, Predict_branchF, expP[i]);
      end
    end
    tests++; if (Predict_targetF !== 32'h102C) begin fails++; $display("FAIL sat_target got %h want 0000102c", Predict_targetF); end
  endtask

  task automatic test_alias();
    train(32'h100, 1, 32'h90);
    drive(0, 0, 0, 0, 0, 32'h200);
    tests++; if (Predict_branchF !== 1'b0 || Predict_targetF !== 32'h204) begin fails++; $display("FAIL alias_lookup got %0b/%h want 0/00000204", Predict_branchF, Predict_targetF); end
    train(32'h200, 0, 32'h400);
    drive(0, 0, 0, 0, 0, 32'h100);
    tests++; if (Predict_branchF !== 1'b0 || Predict_targetF !== 32'h104) begin fails++; $display("FAIL alias_evict got %0b/%h want 0/00000104", Predict_branchF, Predict_targetF); end
    train(32'h200, 1, 32'h480);
    drive(0, 0, 0, 0, 0, 32'h200);
    tests++; if (Predict_branchF !== 1'b1 || Predict_targetF !== 32'h480) begin fails++; $display("FAIL alias_retrain got %0b/%h want 1/00000480", Predict_branchF, Predict_targetF); end
  endtask

  task automatic test_same_cycle();
    drive(1, 32'h140, 1, 32'h60, 0, 32'h140);
    tests++; if (Predict_branchF !== 1'b0 || Predict_targetF !== 32'h144) begin fails++; $display("FAIL rw_same_cycle got %0b/%h want 0/00000144", Predict_branchF, Predict_targetF); end
    tick();
    drive(0, 0, 0, 0, 0, 32'h140);
    tests++; if (Predict_branchF !== 1'b1 || Predict_targetF !== 32'h60) begin fails++; $display("FAIL rw_next_cycle got %0b/%h want 1/00000060", Predict_branchF, Predict_targetF); end
  endtask

  function automatic logic [31:0] randPc();
    return (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 31);
  endfunction

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pce = randPc(), pcf = randPc();
      bit b = ($urandom_range(0, 3) != 0);
      bit tk = $urandom_range(0, 1);
      bit pe = ($urandom_range(0, 3) == 0) ? ~mPred(pce) : mPred(pce);
      drive(b, pce, tk, $urandom, pe, pcf);
      tests++;
      if (Predict_branchF !== mPred(pcf) || Predict_targetF !== mTgt(pcf)
          || MispredictE !== (b && pe != tk)) begin
        fails++;
        if (bad++ < 5) $display("FAIL rand_lookup pc=%h got %0b/%h/%0b want %0b/%h/%0b", pcf,
          Predict_branchF, Predict_targetF, MispredictE, mPred(pcf), mTgt(pcf), b && pe != tk);
      end
      tick();
      tests++;
      if (BranchCount !== mBranch || MispredictCount !== mMisp) begin
        fails++;
        if (bad++ < 5) $display("FAIL rand_counts got %0d/%0d want %0d/%0d", BranchCount, MispredictCount, mBranch, mMisp);
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    force dut.BranchCount = 32'hFFFF_FFFF;
    #1 release dut.BranchCount;
    mBranch = 32'hFFFF_FFFF;
    drive(1, 32'h100, 1, 32'h90, 1, 32'h100);
    tick();
    tests++; if (BranchCount !== 32'h0) begin fails++; $display("FAIL branch_wrap got %h want 00000000", BranchCount); end
    drive(0, 0, 0, 0, 1, 32'h100);
    #1 rst = 0; #1;
    tests++; if (Predict_branchF !== 1'b0 || Predict_targetF !== 32'h104) begin fails++; $display("FAIL async_reset_pred got %0b/%h want 0/00000104", Predict_branchF, Predict_targetF); end
    tests++; if (BranchCount !== 0 || MispredictCount !== 0) begin fails++; $display("FAIL async_reset_counts got %0d/%0d want 0/0", BranchCount, MispredictCount); end
    @(negedge clk);
    rst = 1; mReset();
    train(32'h100, 1, 32'hA0);
    drive(0, 0, 0, 0, 0, 32'h100);
    tests++; if (Predict_branchF !== 1'b1 || BranchCount !== 1) begin fails++; $display("FAIL post_reset_train got %0b/%0d want 1/1", Predict_branchF, BranchCount); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_random();
    test_wrap_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
